// File: rtl/alu_shift_writeback_if.sv
// ----------------------------------------------------------------------------
// alu_shift_writeback_if
//
// Bundles the signals of the shift-writeback stage. These are the shifter
// result handshake, the register-file write port, the status flags, the
// occupancy count and, when WB_BYPASS_EN is defined, the operand bypass
// lookup.
//
// Modports:
//   master - the environment side. It drives the shifter results, wb_grant
//            and byp_rs, and observes the stage outputs.
//   slave  - the alu_shift_writeback stage itself.
//
// Signals:
//   in_valid/in_ready            result handshake
//   in_result/in_rd/in_carry/in_setf  result payload
//   wb_grant                     register-file write port granted
//   rf_we/rf_waddr/rf_wdata      register-file write port
//   flag_z/flag_n/flag_c         status flags
//   count                        buffered entries (CNT_W bits)
//   byp_rs/byp_hit/byp_data      bypass lookup (only with WB_BYPASS_EN)
// ----------------------------------------------------------------------------
interface alu_shift_writeback_if #(
    parameter int unsigned CNT_W = 2
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_result;
    logic [4:0]       in_rd;
    logic             in_carry;
    logic             in_setf;
    logic             wb_grant;
    logic             rf_we;
    logic [4:0]       rf_waddr;
    logic [31:0]      rf_wdata;
    logic             flag_z;
    logic             flag_n;
    logic             flag_c;
    logic [CNT_W-1:0] count;
`ifdef WB_BYPASS_EN
    logic [4:0]       byp_rs;
    logic             byp_hit;
    logic [31:0]      byp_data;
`endif

`ifdef WB_BYPASS_EN
    modport master (
        output in_valid, in_result, in_rd, in_carry, in_setf, wb_grant, byp_rs,
        input  in_ready, rf_we, rf_waddr, rf_wdata, flag_z, flag_n, flag_c, count,
        input  byp_hit, byp_data
    );
    modport slave (
        input  in_valid, in_result, in_rd, in_carry, in_setf, wb_grant, byp_rs,
        output in_ready, rf_we, rf_waddr, rf_wdata, flag_z, flag_n, flag_c, count,
        output byp_hit, byp_data
    );
`else
    modport master (
        output in_valid, in_result, in_rd, in_carry, in_setf, wb_grant,
        input  in_ready, rf_we, rf_waddr, rf_wdata, flag_z, flag_n, flag_c, count
    );
    modport slave (
        input  in_valid, in_result, in_rd, in_carry, in_setf, wb_grant,
        output in_ready, rf_we, rf_waddr, rf_wdata, flag_z, flag_n, flag_c, count
    );
`endif
endinterface

// File: rtl/alu_shift_writeback.sv
// ----------------------------------------------------------------------------
// alu_shift_writeback
//
// Writeback stage behind the 32-bit logical-shift-right unit. Shift results
// are buffered in a small circular FIFO together with their destination
// register, carry-out and set-flags bit. The results are drained in order,
// one per cycle in which the shared register-file write port is granted. The
// Z/N/C flags are updated as entries retire.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - alu_shift_writeback_if.slave. It carries the result handshake, the
//          register-file write port, the flags, the occupancy count and the
//          optional bypass lookup.
//
// Parameters:
//   DEPTH - buffer entries, power of two in 2..8
//   CNT_W - occupancy count width, equal to clog2(DEPTH+1)
//
// Configuration:
//   WB_BYPASS_EN - when defined, adds a combinational bypass lookup
//                  (byp_rs -> byp_hit/byp_data) over the buffered entries
//                  and the output register. When undefined, no comparators
//                  are built.
// ----------------------------------------------------------------------------
module alu_shift_writeback #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 2
) (
    input logic                 clk,
    input logic                 rst,
    alu_shift_writeback_if.slave bus
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Buffer storage
    logic [31:0] mem_result_q [DEPTH];
    logic [4:0]  mem_rd_q     [DEPTH];
    logic        mem_carry_q  [DEPTH];
    logic        mem_setf_q   [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Output register
    logic        rf_we_q, rf_we_d;
    logic [4:0]  rf_waddr_q, rf_waddr_d;
    logic [31:0] rf_wdata_q, rf_wdata_d;
    logic        flag_z_q, flag_z_d;
    logic        flag_n_q, flag_n_d;
    logic        flag_c_q, flag_c_d;

    logic full;
    logic push;
    logic pop;

    logic [31:0] head_result;
    logic [4:0]  head_rd;
    logic        head_carry;
    logic        head_setf;

    // in_ready looks only at the registered count. It does not anticipate a
    // same-cycle pop, which keeps it off the wb_grant arbitration path.
    assign full = (count_q == CNT_W'(DEPTH));
    assign push = bus.in_valid && !full;
    assign pop  = (count_q != '0) && bus.wb_grant;

    assign head_result = mem_result_q[rd_ptr_q];
    assign head_rd     = mem_rd_q[rd_ptr_q];
    assign head_carry  = mem_carry_q[rd_ptr_q];
    assign head_setf   = mem_setf_q[rd_ptr_q];

    // Pointer and occupancy next state. DEPTH is a power of two, so the
    // natural pointer wrap gives the modulo-DEPTH behaviour.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Output register next state. An r0 destination still retires and may
    // update the flags, but it never raises the write enable.
    always_comb begin
        rf_we_d    = pop && (head_rd != 5'd0);
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        flag_z_d   = flag_z_q;
        flag_n_d   = flag_n_q;
        flag_c_d   = flag_c_q;
        if (pop) begin
            rf_waddr_d = head_rd;
            rf_wdata_d = head_result;
            if (head_setf) begin
                flag_z_d = (head_result == 32'd0);
                flag_n_d = head_result[31];
                flag_c_d = head_carry;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= 5'd0;
            rf_wdata_q <= 32'd0;
            flag_z_q   <= 1'b0;
            flag_n_q   <= 1'b0;
            flag_c_q   <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            flag_z_q   <= flag_z_d;
            flag_n_q   <= flag_n_d;
            flag_c_q   <= flag_c_d;
        end
    end

    // Storage has no reset. Reset empties the buffer through the pointers
    // and the count, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_result_q[wr_ptr_q] <= bus.in_result;
            mem_rd_q[wr_ptr_q]     <= bus.in_rd;
            mem_carry_q[wr_ptr_q]  <= bus.in_carry;
            mem_setf_q[wr_ptr_q]   <= bus.in_setf;
        end
    end

    assign bus.in_ready = !full;
    assign bus.rf_we    = rf_we_q;
    assign bus.rf_waddr = rf_waddr_q;
    assign bus.rf_wdata = rf_wdata_q;
    assign bus.flag_z   = flag_z_q;
    assign bus.flag_n   = flag_n_q;
    assign bus.flag_c   = flag_c_q;
    assign bus.count    = count_q;

`ifdef WB_BYPASS_EN
    logic             byp_hit;
    logic [31:0]      byp_data;
    logic [PTR_W-1:0] byp_idx;

    // Scan from oldest to newest so that later matches override earlier
    // ones. The output register is the oldest value, so it is checked first.
    always_comb begin
        byp_hit  = 1'b0;
        byp_data = 32'd0;
        byp_idx  = '0;
        if (bus.byp_rs != 5'd0) begin
            if (rf_we_q && (rf_waddr_q == bus.byp_rs)) begin
                byp_hit  = 1'b1;
                byp_data = rf_wdata_q;
            end
            for (int unsigned i = 0; i < DEPTH; i++) begin
                byp_idx = rd_ptr_q + PTR_W'(i);
                if ((CNT_W'(i) < count_q) && (mem_rd_q[byp_idx] == bus.byp_rs)) begin
                    byp_hit  = 1'b1;
                    byp_data = mem_result_q[byp_idx];
                end
            end
        end
    end

    assign bus.byp_hit  = byp_hit;
    assign bus.byp_data = byp_data;
`endif

endmodule
